// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_regfile
// Description : AXI4-Lite slave holding the command/data registers of a
//               coprocessor wrapper. Five RW registers drive the wrapper
//               directly; two RO inputs (status, data_o) are readable.
//               Map (addr[4:2]): 0x00 data_in, 0x04 address,
//               0x08 start_cc_pointer, 0x0C end_cc_pointer, 0x10 cmd,
//               0x14 status (RO), 0x18 data_o (RO), 0x1C unmapped.
// Ports       : clk/rst (async, active-high); s_axi_aw*/w*/b*/ar*/r* AXI4-Lite
//               slave channels; *_register outputs from the RW registers;
//               status_register/data_o_register read-only inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regfile #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [REG_WIDTH-1:0]    s_axi_wdata,
    input  logic [REG_WIDTH/8-1:0]  s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [REG_WIDTH-1:0]    s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [REG_WIDTH-1:0]    data_in_register,
    output logic [REG_WIDTH-1:0]    address_register,
    output logic [REG_WIDTH-1:0]    start_cc_pointer_register,
    output logic [REG_WIDTH-1:0]    end_cc_pointer_register,
    output logic [REG_WIDTH-1:0]    cmd_register,
    input  logic [REG_WIDTH-1:0]    status_register,
    input  logic [REG_WIDTH-1:0]    data_o_register
);

    localparam int         c_NBYTES      = REG_WIDTH / 8;
    localparam int         c_NUM_RW      = 5;
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // Ready outputs stay low during reset and rise at the first edge after it.
    logic                   r_en;
    logic                   r_aw_held;
    logic [2:0]             r_aw_idx;
    logic                   r_w_held;
    logic [REG_WIDTH-1:0]   r_wdata;
    logic [c_NBYTES-1:0]    r_wstrb;
    logic [REG_WIDTH-1:0]   r_regs [0:c_NUM_RW-1];
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_rvalid;
    logic [REG_WIDTH-1:0]   r_rdata;
    logic [1:0]             r_rresp;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_commit;
    logic                   w_wr_is_rw;
    logic [REG_WIDTH-1:0]   w_old;
    logic [REG_WIDTH-1:0]   w_merged;
    logic [2:0]             w_ar_idx;
    logic [REG_WIDTH-1:0]   w_rd_val;
    logic                   w_unused_addr;

    // Only addr[4:2] decodes; the remaining address bits are ignored.
    assign w_unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = r_en && !r_aw_held && !r_bvalid;
    assign s_axi_wready  = r_en && !r_w_held  && !r_bvalid;
    assign s_axi_arready = r_en && !r_rvalid;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_aw_hs    = s_axi_awvalid && s_axi_awready;
    assign w_w_hs     = s_axi_wvalid  && s_axi_wready;
    assign w_ar_hs    = s_axi_arvalid && s_axi_arready;
    assign w_commit   = r_aw_held && r_w_held;
    assign w_wr_is_rw = (r_aw_idx < 3'd5);
    assign w_ar_idx   = s_axi_araddr[4:2];

    assign data_in_register          = r_regs[0];
    assign address_register          = r_regs[1];
    assign start_cc_pointer_register = r_regs[2];
    assign end_cc_pointer_register   = r_regs[3];
    assign cmd_register              = r_regs[4];

    // Byte-strobe merge of the buffered write data into the target register.
    always_comb begin
        w_old = '0;
        case (r_aw_idx)
            3'd0:    w_old = r_regs[0];
            3'd1:    w_old = r_regs[1];
            3'd2:    w_old = r_regs[2];
            3'd3:    w_old = r_regs[3];
            3'd4:    w_old = r_regs[4];
            default: w_old = '0;
        endcase
        w_merged = w_old;
        for (int i = 0; i < c_NBYTES; i++) begin
            if (r_wstrb[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    // Read mux samples the current register state, so a write committing on
    // the same edge as the AR handshake returns the pre-write value.
    always_comb begin
        w_rd_val = '0;
        case (w_ar_idx)
            3'd0:    w_rd_val = r_regs[0];
            3'd1:    w_rd_val = r_regs[1];
            3'd2:    w_rd_val = r_regs[2];
            3'd3:    w_rd_val = r_regs[3];
            3'd4:    w_rd_val = r_regs[4];
            3'd5:    w_rd_val = status_register;
            3'd6:    w_rd_val = data_o_register;
            default: w_rd_val = '0;
        endcase
    end

    // Write path: AW and W buffer independently; commit once both are held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            for (int k = 0; k < c_NUM_RW; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_en <= 1'b1;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axi_awaddr[4:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_is_rw ? c_RESP_OKAY : c_RESP_SLVERR;
                for (int k = 0; k < c_NUM_RW; k++) begin
                    if (r_aw_idx == 3'(k)) begin
                        r_regs[k] <= w_merged;
                    end
                end
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read path: one-cycle latency, held until the R handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_val;
                r_rresp  <= (w_ar_idx == 3'd7) ? c_RESP_SLVERR : c_RESP_OKAY;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
